// File: rtl/boot_rom_fetch_pkg.sv
// boot_pkg: shared constants and types for the boot ROM fetch path.
//   BOOT_BASE_ADDR  byte address of ROM word 0
//   BOOT_ROM_DEPTH  number of valid 32-bit ROM words
//   BOOT_ROM_AW     ROM word-address width
//   RV_NOP          canonical RISC-V nop, reserved for shared use
//   fetch_rsp_t     response payload (instruction word + access fault)
package boot_pkg;

  localparam logic [31:0] BOOT_BASE_ADDR = 32'h0000_0000;
  localparam int unsigned BOOT_ROM_DEPTH = 14;
  localparam int unsigned BOOT_ROM_AW    = 4;
  localparam logic [31:0] RV_NOP         = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } fetch_rsp_t;

endpackage

// File: rtl/boot_rom_fetch.sv
// boot_rom_fetch: fetch-side initiator for the boot ROM.
// Translates byte PCs from the core front end into ROM word indices, absorbs
// the ROM's 1-cycle registered read and returns words on a valid/ready
// response channel with backpressure and flush.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready request handshake, req_pc = fetch byte address
//   rsp_valid/rsp_ready response handshake
//   rsp_data, rsp_err   instruction word / access fault (misaligned or OOR)
//   flush               core redirect, drops pending response
//   rom_addr, rom_data  boot_rom word address / read data (1-cycle latency)
//   fetch_cnt, fault_cnt  saturating handshake counters, present only when
//                         BOOT_FETCH_PERF_EN is defined
module boot_rom_fetch
  import boot_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BOOT_BASE_ADDR,
  parameter int unsigned DEPTH     = BOOT_ROM_DEPTH,
  parameter int unsigned ADDR_W    = BOOT_ROM_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_pc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  input  logic              flush,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data
`ifdef BOOT_FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [15:0]       fault_cnt
`endif
);

  logic              accept;
  logic              dec_err;
  logic [31:0]       off;
  logic [29:0]       idx;
  logic [ADDR_W-1:0] held_addr;
  logic              err_q;
  fetch_rsp_t        rsp;

  // rst gates req_ready so nothing is accepted in the reset cycle.
  assign req_ready = !rst && !flush && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    off     = req_pc - BASE_ADDR;
    idx     = off[31:2];
    dec_err = (off[1:0] != 2'b00) || (idx >= 30'(DEPTH));
  end

  // The ROM address only moves for good accepted requests, so rom_data stays
  // stable while a response is stalled or after a faulting request.
  assign rom_addr = (accept && !dec_err) ? idx[ADDR_W-1:0] : held_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      err_q     <= 1'b0;
      held_addr <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      err_q     <= dec_err;
      if (!dec_err) held_addr <= idx[ADDR_W-1:0];
    end else if (flush || rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  always_comb begin
    rsp.err  = err_q;
    rsp.data = err_q ? '0 : rom_data;
  end

  assign rsp_data = rsp.data;
  assign rsp_err  = rsp.err;

`ifdef BOOT_FETCH_PERF_EN
  // A response shown during a flush cycle is not consumed.
  logic rsp_hs;
  assign rsp_hs = rsp_valid && rsp_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      fault_cnt <= '0;
    end else if (rsp_hs) begin
      if (err_q) begin
        if (fault_cnt != '1) fault_cnt <= fault_cnt + 16'd1;
      end else begin
        if (fetch_cnt != '1) fetch_cnt <= fetch_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_boot_rom_fetch.sv
module tb_boot_rom_fetch;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned DEPTH = 14;
  localparam int unsigned AW    = 4;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_pc;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_data;
  logic          rsp_err;
  logic          flush;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_data;
`ifdef BOOT_FETCH_PERF_EN
  logic [31:0]   fetch_cnt;
  logic [15:0]   fault_cnt;
`endif

  int checks;
  int errors;

  boot_rom_fetch #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_pc    (req_pc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .flush     (flush),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data)
`ifdef BOOT_FETCH_PERF_EN
    ,
    .fetch_cnt (fetch_cnt),
    .fault_cnt (fault_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Boot ROM stand-in: registered read, 1-cycle latency.
  logic [31:0] rom [16];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Reference model: at most one outstanding response plus the held word index.
  bit          m_pend;
  bit          m_err;
  logic [31:0] m_data;
  int unsigned m_held;
  int unsigned m_fetch;
  int unsigned m_fault;

  function automatic bit dec_err(input logic [31:0] pc);
    logic [31:0] o;
    o = pc - BASE;
    return (o % 4 != 0) || ((o / 4) >= DEPTH);
  endfunction

  function automatic int unsigned dec_idx(input logic [31:0] pc);
    return (pc - BASE) / 4;
  endfunction

  // Advance the model with the inputs currently applied, then move to 1 time
  // unit after the next rising edge.
  task automatic tick();
    bit acc;
    bit hs;
    acc = req_valid && !rst && !flush && (!m_pend || rsp_ready);
    hs  = m_pend && rsp_ready && !flush;
    if (rst) begin
      m_pend = 0; m_err = 0; m_held = 0; m_fetch = 0; m_fault = 0;
    end else begin
      if (hs) begin
        if (m_err) begin
          if (m_fault < 65535) m_fault++;
        end else if (m_fetch < 32'hFFFF_FFFF) begin
          m_fetch++;
        end
      end
      if (acc) begin
        m_pend = 1;
        m_err  = dec_err(req_pc);
        m_data = m_err ? 32'h0 : rom[dec_idx(req_pc)];
        if (!m_err) m_held = dec_idx(req_pc);
      end else if (flush || rsp_ready) begin
        m_pend = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; req_valid = 1; req_pc = 32'h0; rsp_ready = 1; flush = 0;
    tick();
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready);
    end
    tick();
    rst = 0; req_valid = 0;
    #1;
    checks++;
    if ({rsp_valid, rsp_err, rom_addr, req_ready} !== {1'b0, 1'b0, 4'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got valid=%b err=%b addr=%h ready=%b want 0 0 0 1",
               rsp_valid, rsp_err, rom_addr, req_ready);
    end
  endtask

  task automatic test_first_fetch();
    req_valid = 1; req_pc = 32'h0; rsp_ready = 1;
    #1;
    tick();
    req_valid = 0;
    #1;
    checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 32'h8000_00b7}) begin
      errors++;
      $display("FAIL first_fetch: got valid=%b err=%b data=%h want 1 0 800000b7",
               rsp_valid, rsp_err, rsp_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [3];
    logic [31:0] exp [3];
    pcs = '{32'h0, 32'h4, 32'h8};
    exp = '{32'h8000_00b7, 32'h1000_0137, 32'h0000_a203};
    rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      req_valid = (i < 3);
      if (i < 3) req_pc = pcs[i];
      #1;
      if (i > 0) begin
        checks++;
        if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, exp[i-1]}) begin
          errors++;
          $display("FAIL back_to_back[%0d]: got valid=%b err=%b data=%h want 1 0 %h",
                   i - 1, rsp_valid, rsp_err, rsp_data, exp[i-1]);
        end
      end
      tick();
    end
  endtask

  task automatic test_errors();
    rsp_ready = 1;
    req_valid = 1; req_pc = 32'h34;
    #1;
    checks++;
    if (rom_addr !== 4'd13) begin
      errors++; $display("FAIL err_pre_addr: got %h want d", rom_addr);
    end
    tick();
    req_pc = 32'h38;
    #1;
    checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 32'h0003_80e7}) begin
      errors++;
      $display("FAIL fetch_34: got valid=%b err=%b data=%h want 1 0 000380e7",
               rsp_valid, rsp_err, rsp_data);
    end
    checks++;
    if (rom_addr !== 4'd13) begin
      errors++; $display("FAIL oor_addr_held: got %h want d", rom_addr);
    end
    tick();
    req_pc = 32'h2;
    #1;
    checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL fetch_38_oor: got valid=%b err=%b data=%h want 1 1 00000000",
               rsp_valid, rsp_err, rsp_data);
    end
    checks++;
    if (rom_addr !== 4'd13) begin
      errors++; $display("FAIL misalign_addr_held: got %h want d", rom_addr);
    end
    tick();
    req_valid = 0;
    #1;
    checks++;
    if ({rsp_valid, rsp_err, rsp_data, rom_addr} !== {1'b1, 1'b1, 32'h0, 4'd13}) begin
      errors++;
      $display("FAIL fetch_2_misalign: got valid=%b err=%b data=%h addr=%h want 1 1 00000000 d",
               rsp_valid, rsp_err, rsp_data, rom_addr);
    end
    tick();
  endtask

  task automatic test_backpressure();
    req_valid = 1; req_pc = 32'h14; rsp_ready = 1;
    #1;
    tick();
    req_valid = 1; req_pc = 32'h0; rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({rsp_valid, rsp_err, rsp_data, req_ready, rom_addr} !==
          {1'b1, 1'b0, 32'h0041_de63, 1'b0, 4'd5}) begin
        errors++;
        $display("FAIL stall[%0d]: got valid=%b err=%b data=%h ready=%b addr=%h want 1 0 0041de63 0 5",
                 i, rsp_valid, rsp_err, rsp_data, req_ready, rom_addr);
      end
      tick();
    end
    req_valid = 0; rsp_ready = 1;
    #1;
    checks++;
    if ({rsp_valid, rsp_data, req_ready} !== {1'b1, 32'h0041_de63, 1'b1}) begin
      errors++;
      $display("FAIL stall_release: got valid=%b data=%h ready=%b want 1 0041de63 1",
               rsp_valid, rsp_data, req_ready);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL stall_done: got valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_flush();
    req_valid = 1; req_pc = 32'h18; rsp_ready = 1;
    #1;
    tick();
    req_valid = 1; req_pc = 32'h1C; rsp_ready = 0; flush = 1;
    #1;
    checks++;
    if ({rsp_valid, req_ready} !== {1'b1, 1'b0}) begin
      errors++;
      $display("FAIL flush_cycle: got valid=%b ready=%b want 1 0", rsp_valid, req_ready);
    end
    tick();
    flush = 0; req_valid = 0; rsp_ready = 1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL flush_drop: got valid=%b want 0", rsp_valid);
    end
    tick();
    req_valid = 1; req_pc = 32'h1C;
    #1;
    tick();
    req_valid = 0;
    #1;
    checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 32'h0002_a303}) begin
      errors++;
      $display("FAIL after_flush: got valid=%b err=%b data=%h want 1 0 0002a303",
               rsp_valid, rsp_err, rsp_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    req_valid = 1; req_pc = 32'h4; rsp_ready = 1;
    #1;
    tick();
    rsp_ready = 0; rst = 1; req_valid = 1; req_pc = 32'h8;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid_ready: got %b want 0", req_ready);
    end
    tick();
    rst = 0; req_valid = 0; rsp_ready = 1;
    #1;
    checks++;
    if ({rsp_valid, rom_addr} !== {1'b0, 4'd0}) begin
      errors++;
      $display("FAIL rst_mid_state: got valid=%b addr=%h want 0 0", rsp_valid, rom_addr);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_no_rsp: got valid=%b want 0", rsp_valid);
    end
  endtask

`ifdef BOOT_FETCH_PERF_EN
  task automatic test_perf();
    logic [31:0] pcs [5];
    pcs = '{32'h0, 32'h38, 32'h4, 32'h3, 32'h8};
    rsp_ready = 1;
    for (int i = 0; i < 6; i++) begin
      req_valid = (i < 5);
      if (i < 5) req_pc = pcs[i];
      #1;
      tick();
    end
    req_valid = 0;
    checks++;
    if ({fetch_cnt, fault_cnt} !== {32'd3, 16'd2}) begin
      errors++;
      $display("FAIL perf_counts: got fetch=%0d fault=%0d want 3 2", fetch_cnt, fault_cnt);
    end
    rst = 1;
    #1;
    tick();
    rst = 0;
    #1;
    checks++;
    if ({fetch_cnt, fault_cnt} !== {32'd0, 16'd0}) begin
      errors++;
      $display("FAIL perf_reset: got fetch=%0d fault=%0d want 0 0", fetch_cnt, fault_cnt);
    end
    tick();
  endtask
`endif

  task automatic test_random();
    bit          acc;
    bit          e;
    int unsigned idx;
    bit          exp_ready;
    logic [3:0]  exp_addr;
    int unsigned sel;
    for (int i = 0; i < 600; i++) begin
      sel       = $urandom_range(0, 9);
      req_valid = ($urandom_range(0, 3) != 0);
      if (sel < 7)       req_pc = BASE + 4 * $urandom_range(0, DEPTH - 1);
      else if (sel == 7) req_pc = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
      else if (sel == 8) req_pc = BASE + 4 * $urandom_range(DEPTH, DEPTH + 8);
      else               req_pc = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 63) == 0);
      #1;
      exp_ready = !rst && !flush && (!m_pend || rsp_ready);
      acc       = req_valid && exp_ready;
      e         = dec_err(req_pc);
      idx       = dec_idx(req_pc);
      exp_addr  = (acc && !e) ? 4'(idx) : 4'(m_held);
      checks++;
      if ({req_ready, rom_addr, rsp_valid} !== {exp_ready, exp_addr, m_pend}) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: got ready=%b addr=%h valid=%b want %b %h %b",
                 i, req_ready, rom_addr, rsp_valid, exp_ready, exp_addr, m_pend);
      end
      if (m_pend) begin
        checks++;
        if ({rsp_err, rsp_data} !== {m_err, m_data}) begin
          errors++;
          $display("FAIL rand_rsp[%0d]: got err=%b data=%h want %b %h",
                   i, rsp_err, rsp_data, m_err, m_data);
        end
      end
`ifdef BOOT_FETCH_PERF_EN
      checks++;
      if ({fetch_cnt, fault_cnt} !== {32'(m_fetch), 16'(m_fault)}) begin
        errors++;
        $display("FAIL rand_perf[%0d]: got fetch=%0d fault=%0d want %0d %0d",
                 i, fetch_cnt, fault_cnt, m_fetch, m_fault);
      end
`endif
      tick();
    end
    rst = 0; flush = 0; req_valid = 0; rsp_ready = 1;
    #1;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_pend = 0; m_err = 0; m_data = 32'h0; m_held = 0; m_fetch = 0; m_fault = 0;
    rom[0]  = 32'h8000_00b7; rom[1]  = 32'h1000_0137; rom[2]  = 32'h0000_a203;
    rom[3]  = 32'h0030_a023; rom[4]  = 32'h0040_0193; rom[5]  = 32'h0041_de63;
    rom[6]  = 32'h0080_0293; rom[7]  = 32'h0002_a303; rom[8]  = 32'h0062_0233;
    rom[9]  = 32'hfff1_8193; rom[10] = 32'hfe01_9ae3; rom[11] = 32'h0000_00b7;
    rom[12] = 32'h0000_8093; rom[13] = 32'h0003_80e7; rom[14] = 32'hdead_beef;
    rom[15] = 32'hcafe_f00d;
    rst = 1; req_valid = 0; req_pc = 32'h0; rsp_ready = 1; flush = 0;

    test_reset();
    test_first_fetch();
    test_back_to_back();
    test_errors();
    test_backpressure();
    test_flush();
    test_reset_mid();
`ifdef BOOT_FETCH_PERF_EN
    test_perf();
`endif
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
